// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter steering one 4:1 select into a registered valid/ready output stage.
// Optional packet lock (in_last/out_last) is built when RR_MUX_ARBITER_PKT_LOCK_EN is defined.
module rr_mux_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_id,
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  input  logic [3:0]     in_last,
  output logic           out_last,
`endif
  input  logic           out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

  ostate_e      state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   id_q, id_d;

  logic [3:0]   gnt;
  logic [1:0]   gnt_idx;
  logic [1:0]   idx;
  logic         found;
  logic         can_load;
  logic         xfer;

`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  logic         lock_q, lock_d;
  logic [1:0]   lock_id_q, lock_id_d;
  logic         last_q, last_d;
`endif

  assign can_load = (state_q == EMPTY) | out_ready;

  // Search order ptr+1 .. ptr+4 (= ptr), so the last served requester ranks lowest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && in_valid[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    if (lock_q) begin
      gnt_idx = lock_id_q;
      found   = in_valid[lock_id_q];
    end
`endif
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign in_ready = gnt & {4{can_load & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    id_d   = id_q;
    if (xfer) begin
      ptr_d  = gnt_idx;
      data_d = in_data[32'(gnt_idx)*W +: W];
      id_d   = gnt_idx;
    end
  end

`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  // Only lock_id can transfer while locked, so a last word always comes from the lock owner.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    if (xfer) begin
      lock_d    = ~in_last[gnt_idx];
      lock_id_d = gnt_idx;
      last_d    = in_last[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      last_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

  assign out_last = last_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd3;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: vector table for arbitration/backpressure, hand sequences for reset and packet lock.
module tb_rr_mux_arbiter;
  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready;
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  logic [3:0]     in_last;
  logic           out_last;
`endif

  int total;
  int bad;

  rr_mux_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [3:0]  e_od;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [3:0] vld, logic [15:0] data, logic rdy,
                              logic [3:0] e_rdy, logic e_ov, logic [3:0] e_od, logic [1:0] e_id);
    vec_t v;
    v.vld = vld; v.data = data; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_id = e_id;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    in_last   = '1;
`endif

    // Expected values derive from ptr=3 after reset and the ptr+1.. search order.
    tbl[0]  = mk(4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    tbl[1]  = mk(4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    tbl[2]  = mk(4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
    tbl[3]  = mk(4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    tbl[4]  = mk(4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    tbl[5]  = mk(4'b1010, 16'h3C7A, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1);
    tbl[6]  = mk(4'b1010, 16'h3C7A, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3);
    tbl[7]  = mk(4'b1010, 16'h3C7A, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1);
    tbl[8]  = mk(4'b1010, 16'h3C7A, 1'b1, 4'b1000, 1'b1, 4'h3, 2'd3);
    tbl[9]  = mk(4'b0001, 16'hDCB5, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
    tbl[10] = mk(4'b1111, 16'hDCB5, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd0);
    tbl[11] = mk(4'b1111, 16'hDCB5, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd0);
    tbl[12] = mk(4'b1111, 16'hDCB5, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd0);
    tbl[13] = mk(4'b1111, 16'hDCB5, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    tbl[14] = mk(4'b0000, 16'hDCB5, 1'b1, 4'b0000, 1'b0, 4'hB, 2'd1);
    tbl[15] = mk(4'b0001, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    tbl[16] = mk(4'b0100, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0);
    tbl[17] = mk(4'b0001, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    tbl[18] = mk(4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd0);

    // Power-on reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 0xA, stall, then assert reset between clock edges
    @(negedge clk);
    in_valid = 4'b0001; in_data = 16'hDCBA; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_load_valid", 32'(out_valid), 32'd1);
    chk("pre_load_data",  32'(out_data),  32'hA);
    @(negedge clk);
    in_valid = 4'b1111;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid",    32'(out_valid), 32'd0);
    chk("async_rst_data",     32'(out_data),  32'd0);
    chk("async_rst_id",       32'(out_id),    32'd0);
    chk("async_rst_in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_id",    32'(out_id),    32'd0);
    chk("post_rst_data",  32'(out_data),  32'hA);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].data;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].e_od));
      chk($sformatf("v%0d_out_id", i),    32'(out_id),    32'(tbl[i].e_id));
    end

`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    do_reset();
    // Requester 1 packet (last=0,0,1) against a continuously valid requester 2
    @(negedge clk);
    in_valid = 4'b0110; in_data = 16'h4321; in_last = 4'b0000; out_ready = 1'b1;
    #1;
    chk("lk_a_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("lk_a_id",   32'(out_id),   32'd1);
    chk("lk_a_last", 32'(out_last), 32'd0);
    @(negedge clk);
    in_valid = 4'b0100;
    #1;
    chk("lk_b_ready", 32'(in_ready), 32'b0000);
    @(posedge clk); #1;
    chk("lk_b_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 4'b0110; in_last = 4'b0000;
    #1;
    chk("lk_c_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("lk_c_id", 32'(out_id), 32'd1);
    @(negedge clk);
    in_last = 4'b0010;
    #1;
    chk("lk_d_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("lk_d_id",   32'(out_id),   32'd1);
    chk("lk_d_last", 32'(out_last), 32'd1);
    @(negedge clk);
    in_last = 4'b1111;
    #1;
    chk("lk_e_ready", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    chk("lk_e_id",   32'(out_id),   32'd2);
    chk("lk_e_data", 32'(out_data), 32'h3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
